// File: rtl/mix_add_round_key.sv
// AES round tail: MixColumns (one column per cycle through a shared col_oper)
// followed by AddRoundKey, with valid/ready handshakes on both sides.

module col_oper (
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        a0 = col_in[0:7];
        a1 = col_in[8:15];
        a2 = col_in[16:23];
        a3 = col_in[24:31];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        col_out = {b0, b1, b2, b3};
    end

endmodule

module mix_add_round_key (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic [0:127] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned COL_W  = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [0:DATA_W-1]  st_q, st_d;
    logic [0:DATA_W-1]  key_q, key_d;
    logic               last_q, last_d;
    logic [0:DATA_W-1]  res_q, res_d;
    logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [0:COL_W-1]   col_in_c;
    logic [0:COL_W-1]   col_out_c;
    logic [0:COL_W-1]   mixed_c;
    logic [6:0]         col_base_c;

    col_oper u_col_oper (
        .col_in  (col_in_c),
        .col_out (col_out_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            last_q      <= 1'b0;
            res_q       <= '0;
            col_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            last_q      <= last_d;
            res_q       <= res_d;
            col_cnt_q   <= col_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Column select, MixColumns bypass on the final round, and the FSM
    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        key_d      = key_q;
        last_d     = last_q;
        res_d      = res_q;
        col_cnt_d  = col_cnt_q;
        col_base_c = {col_cnt_q, 5'd0};
        col_in_c   = st_q[col_base_c +: COL_W];
        mixed_c    = last_q ? col_in_c : col_out_c;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d      = in_state;
                    key_d     = in_key;
                    last_d    = in_last;
                    col_cnt_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                res_d[col_base_c +: COL_W] = mixed_c ^ key_q[col_base_c +: COL_W];
                col_cnt_d = CNT_W'(col_cnt_q + 2'd1);
                if (col_cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are flopped from the next state, so no input-to-output path
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = res_q;

endmodule

// File: tb/tb_mix_add_round_key.sv
// Self-checking bench for mix_add_round_key: known-answer table, random vectors
// against a byte-level GF(2^8) model, and handshake/reset corner sequences.

module tb_mix_add_round_key;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic [0:127] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mix_add_round_key dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    typedef struct {
        logic [0:127] st;
        logic [0:127] key;
        logic         last;
        logic [0:127] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x[7]) ? (8'((x << 1)) ^ 8'h1b) : 8'(x << 1);
        end
        return p;
    endfunction

    // Reference: state as a 16-byte array, column c = bytes 4c..4c+3
    function automatic logic [0:127] ref_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] o [16];
        logic [0:127] r;
        for (int i = 0; i < 16; i++) a[i] = s[8*i +: 8];
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                if (last)
                    o[4*c+rr] = a[4*c+rr];
                else
                    o[4*c+rr] = gmul(a[4*c+rr], 8'd2) ^ gmul(a[4*c+(rr+1)%4], 8'd3)
                              ^ a[4*c+(rr+2)%4] ^ a[4*c+(rr+3)%4];
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = o[i] ^ k[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one vector, measure latency, check result, then consume it
    task automatic run_op(input string name, input vec_t v);
        int lat;
        chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = v.st;
        in_key   = v.key;
        in_last  = v.last;
        step();
        in_valid = 1'b0;
        in_state = rnd128();
        in_key   = rnd128();
        in_last  = ~v.last;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd4);
        chk({name, "_result"}, out_state, v.exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_idle"}, 128'({in_ready, out_valid}), 128'b10);
    endtask

    vec_t tbl [3];
    vec_t v;
    logic [0:127] hold;

    initial begin
        tbl[0] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                   1'b0, 128'ha49c7ff2_689f352b_6b5bea43_026a5049};
        tbl[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h0, 1'b1,
                   128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        tbl[2] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b0,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_state = rnd128(); in_key = rnd128(); in_last = 1'b0;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("reset_flags", 128'({in_ready, out_valid}), 128'b10);
        chk("reset_out_state", out_state, 128'h0);

        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("table%0d", i), tbl[i]);
        end

        for (int i = 0; i < 20; i++) begin
            v.st   = rnd128();
            v.key  = rnd128();
            v.last = 1'($urandom_range(0, 1));
            v.exp  = ref_round(v.st, v.key, v.last);
            run_op($sformatf("rand%0d", i), v);
        end

        // Backpressure: result must hold while inputs churn
        v = tbl[0];
        in_valid = 1'b1; in_state = v.st; in_key = v.key; in_last = v.last;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_valid", 128'(out_valid), 128'd1);
        hold = out_state;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = rnd128();
            in_key   = rnd128();
            step();
            chk($sformatf("bp_hold%0d", i), out_state, v.exp);
            chk($sformatf("bp_flags%0d", i), 128'({in_ready, out_valid}), 128'b01);
        end
        chk("bp_stable", out_state, hold);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", 128'({in_ready, out_valid}), 128'b10);
        run_op("bp_next", tbl[2]);

        // Reset two edges after acceptance discards the operation
        in_valid = 1'b1; in_state = tbl[0].st; in_key = tbl[0].key; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_flags", 128'({in_ready, out_valid}), 128'b10);
        chk("mid_rst_out", out_state, 128'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("mid_rst_quiet%0d", i), 128'(out_valid), 128'd0);
        end
        run_op("after_rst", tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
